prga_decrypt_engine: RTL

PRGA_DECRYPT_ENGINE -- requirements
Module: prga_decrypt_engine

---
 rtl/prga_pkg.sv | 28 ++
 rtl/prga_char_check.sv | 22 ++
 rtl/prga_decrypt_engine.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/prga_pkg.sv
// Shared definitions for the RC4 PRGA decrypt engine.
//   state_e  : FSM state encoding. Every RAM read state is followed by a
//              wait state because RAM data arrives one cycle after the address.
//   CHAR_LO  : default lowest valid plaintext byte ('a').
//   CHAR_HI  : default highest valid plaintext byte ('z').
//   SPACE    : the space character, optionally also valid.
package prga_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WAIT_SI,
        CALC_J,
        RD_SJ,
        WAIT_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WAIT_F,
        XOR_WR,
        DONE
    } state_e;

    localparam logic [7:0] CHAR_LO = 8'd97;
    localparam logic [7:0] CHAR_HI = 8'd122;
    localparam logic [7:0] SPACE   = 8'd32;

endpackage

// File: rtl/prga_char_check.sv
// Combinational plaintext validity test.
//   char_in : decrypted byte under test
//   valid   : 1 when CHAR_LO <= char_in <= CHAR_HI, or when ALLOW_SPACE is
//             set and char_in is a space
module prga_char_check #(
    parameter logic [7:0] CHAR_LO     = prga_pkg::CHAR_LO,
    parameter logic [7:0] CHAR_HI     = prga_pkg::CHAR_HI,
    parameter bit         ALLOW_SPACE = 1'b1
) (
    input  logic [7:0] char_in,
    output logic       valid
);
    import prga_pkg::SPACE;

    logic in_range;
    logic is_space;

    assign in_range = (char_in >= CHAR_LO) && (char_in <= CHAR_HI);
    assign is_space = ALLOW_SPACE && (char_in == SPACE);
    assign valid    = in_range || is_space;

endmodule

// File: rtl/prga_decrypt_engine.sv
// RC4 keystream generation (PRGA) and message decryption.
// Runs over an already-shuffled S array in external RAM, XORs the keystream
// with the encrypted message ROM and writes the result to a decrypted RAM,
// checking each plaintext byte against a character class.
//   clk, rst      : clock and asynchronous active-high reset
//   start         : level; S shuffle complete, run may begin / stay in DONE
//   in_data_s     : S RAM read data        in_data_m : message ROM read data
//   mem_address_s / out_data_s / wren_s : S RAM port
//   mem_address_m : message ROM address (k)
//   mem_address_d / out_data_d / wren_d : decrypted RAM port
//   busy, done    : run in progress / run finished (held until start drops)
//   fail_sig, fail_index : first invalid plaintext byte seen, and its index
//   led0          : done and no invalid byte
module prga_decrypt_engine #(
    parameter int         MSG_LEN       = 32,
    parameter bit         ABORT_ON_FAIL = 1'b1,
    parameter logic [7:0] CHAR_LO       = prga_pkg::CHAR_LO,
    parameter logic [7:0] CHAR_HI       = prga_pkg::CHAR_HI,
    parameter bit         ALLOW_SPACE   = 1'b1,
    localparam int        MW            = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    in_data_s,
    input  logic [7:0]    in_data_m,
    output logic [7:0]    mem_address_s,
    output logic [7:0]    out_data_s,
    output logic          wren_s,
    output logic [MW-1:0] mem_address_m,
    output logic [MW-1:0] mem_address_d,
    output logic [7:0]    out_data_d,
    output logic          wren_d,
    output logic          busy,
    output logic          done,
    output logic          fail_sig,
    output logic [MW-1:0] fail_index,
    output logic          led0
);
    import prga_pkg::*;

    localparam logic [MW-1:0] K_LAST = MW'(MSG_LEN - 1);

    state_e        state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [7:0]    si_q, si_d;      // old s[i], kept for the swap and f address
    logic [7:0]    sj_q, sj_d;      // old s[j]
    logic [MW-1:0] k_q, k_d;
    logic          fail_q, fail_d;
    logic [MW-1:0] fail_idx_q, fail_idx_d;

    logic [7:0]    plain;
    logic          plain_ok;

    assign plain = in_data_s ^ in_data_m;

    prga_char_check #(
        .CHAR_LO     (CHAR_LO),
        .CHAR_HI     (CHAR_HI),
        .ALLOW_SPACE (ALLOW_SPACE)
    ) u_char_check (
        .char_in (plain),
        .valid   (plain_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            k_q        <= '0;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            k_q        <= k_d;
            fail_q     <= fail_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // The S address is held through each wait state and the sampling state:
    // the RAM re-reads every cycle, so the data stays valid only while the
    // address does.
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        si_d          = si_q;
        sj_d          = sj_q;
        k_d           = k_q;
        fail_d        = fail_q;
        fail_idx_d    = fail_idx_q;
        mem_address_s = '0;
        out_data_s    = '0;
        wren_s        = 1'b0;
        out_data_d    = '0;
        wren_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD_SI;
                    i_d        = '0;
                    j_d        = '0;
                    k_d        = '0;
                    fail_d     = 1'b0;
                    fail_idx_d = '0;
                end
            end
            RD_SI: begin
                i_d           = i_q + 8'd1;
                mem_address_s = i_q + 8'd1;
                state_d       = WAIT_SI;
            end
            WAIT_SI: begin
                mem_address_s = i_q;
                state_d       = CALC_J;
            end
            CALC_J: begin
                mem_address_s = i_q;
                si_d          = in_data_s;
                j_d           = j_q + in_data_s;
                state_d       = RD_SJ;
            end
            RD_SJ: begin
                mem_address_s = j_q;
                state_d       = WAIT_SJ;
            end
            WAIT_SJ: begin
                mem_address_s = j_q;
                state_d       = WR_SI;
            end
            WR_SI: begin
                // s[j] arrives this cycle; forward it straight into s[i].
                mem_address_s = i_q;
                out_data_s    = in_data_s;
                wren_s        = 1'b1;
                sj_d          = in_data_s;
                state_d       = WR_SJ;
            end
            WR_SJ: begin
                mem_address_s = j_q;
                out_data_s    = si_q;
                wren_s        = 1'b1;
                state_d       = RD_F;
            end
            RD_F: begin
                mem_address_s = si_q + sj_q;
                state_d       = WAIT_F;
            end
            WAIT_F: begin
                mem_address_s = si_q + sj_q;
                state_d       = XOR_WR;
            end
            XOR_WR: begin
                mem_address_s = si_q + sj_q;
                out_data_d    = plain;
                wren_d        = 1'b1;
                if (!plain_ok && !fail_q) begin
                    fail_d     = 1'b1;
                    fail_idx_d = k_q;
                end
                if ((!plain_ok && ABORT_ON_FAIL) || (k_q == K_LAST)) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MW'(1);
                    state_d = RD_SI;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_address_m = k_q;
    assign mem_address_d = k_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign fail_sig      = fail_q;
    assign fail_index    = fail_idx_q;
    assign led0          = done && !fail_q;

endmodule
